// File: rtl/id_pkg.sv
// Shared decode constants and selector types for the registered decode stage.
package id_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [4:0] TYPE_ARITH = 5'b10000;
  localparam logic [4:0] TYPE_LOGIC = 5'b01000;
  localparam logic [4:0] TYPE_LDST  = 5'b00100;
  localparam logic [4:0] TYPE_JUMP  = 5'b00010;
  localparam logic [4:0] TYPE_SYS   = 5'b00001;

  localparam logic [7:0] ALU_ADD   = 8'h11;
  localparam logic [7:0] ALU_SUB   = 8'h12;
  localparam logic [7:0] ALU_SLT   = 8'h13;
  localparam logic [7:0] ALU_SLTU  = 8'h14;
  localparam logic [7:0] ALU_LUI   = 8'h15;
  localparam logic [7:0] ALU_AUIPC = 8'h16;
  localparam logic [7:0] ALU_AND   = 8'h21;
  localparam logic [7:0] ALU_OR    = 8'h22;
  localparam logic [7:0] ALU_XOR   = 8'h23;
  localparam logic [7:0] ALU_SLL   = 8'h24;
  localparam logic [7:0] ALU_SRL   = 8'h25;
  localparam logic [7:0] ALU_SRA   = 8'h26;
  localparam logic [7:0] JMP_JAL   = 8'h41;
  localparam logic [7:0] JMP_JALR  = 8'h42;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_SHAMT,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef enum logic [1:0] {
    OP1_RS1,
    OP1_PC,
    OP1_ZERO
  } op1_sel_e;

  typedef enum logic [1:0] {
    OP2_RS2,
    OP2_IMM,
    OP2_FOUR
  } op2_sel_e;

  function automatic int unsigned shamt_width(input int unsigned data_width);
    return (data_width == 64) ? 6 : 5;
  endfunction

endpackage

// File: rtl/id_stage_pipe_decode.sv
// Combinational instruction classifier: class, operation code, immediate and port usage.
module id_decode
  import id_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic [31:0]           inst,
  output logic                  illegal,
  output logic [4:0]            inst_type,
  output logic [7:0]            inst_opcode,
  output logic [DATA_WIDTH-1:0] imm,
  output logic                  rs1_used,
  output logic                  rs2_used,
  output op1_sel_e              op1_sel,
  output op2_sel_e              op2_sel,
  output logic                  rd_w_ena,
  output logic [4:0]            rd_w_addr
);

  localparam int unsigned SHAMT_W = shamt_width(DATA_WIDTH);
  localparam logic [6:0]  F7_BASE = 7'b0000000;
  localparam logic [6:0]  F7_ALT  = 7'b0100000;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic       shamt_hi_bad;
  imm_fmt_e   imm_fmt;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign rd     = inst[11:7];
  // On a 32-bit datapath inst[25] would be shamt[5], which does not exist.
  assign shamt_hi_bad = (SHAMT_W == 5) ? inst[25] : 1'b0;

  always_comb begin
    illegal     = 1'b0;
    inst_type   = '0;
    inst_opcode = '0;
    imm_fmt     = IMM_NONE;
    rs1_used    = 1'b0;
    rs2_used    = 1'b0;
    op1_sel     = OP1_RS1;
    op2_sel     = OP2_IMM;
    case (opcode)
      OPC_OP_IMM: begin
        rs1_used  = 1'b1;
        imm_fmt   = IMM_I;
        inst_type = TYPE_ARITH;
        case (funct3)
          3'b000: inst_opcode = ALU_ADD;
          3'b010: inst_opcode = ALU_SLT;
          3'b011: inst_opcode = ALU_SLTU;
          3'b100: begin inst_type = TYPE_LOGIC; inst_opcode = ALU_XOR; end
          3'b110: begin inst_type = TYPE_LOGIC; inst_opcode = ALU_OR;  end
          3'b111: begin inst_type = TYPE_LOGIC; inst_opcode = ALU_AND; end
          3'b001: begin
            inst_type   = TYPE_LOGIC;
            inst_opcode = ALU_SLL;
            imm_fmt     = IMM_SHAMT;
            illegal     = (inst[31:26] != 6'b000000) || shamt_hi_bad;
          end
          default: begin
            inst_type   = TYPE_LOGIC;
            inst_opcode = inst[30] ? ALU_SRA : ALU_SRL;
            imm_fmt     = IMM_SHAMT;
            illegal     = ({inst[31], inst[29:26]} != 5'b00000) || shamt_hi_bad;
          end
        endcase
      end
      OPC_OP: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        op2_sel  = OP2_RS2;
        case ({funct7, funct3})
          {F7_BASE, 3'b000}: begin inst_type = TYPE_ARITH; inst_opcode = ALU_ADD;  end
          {F7_ALT,  3'b000}: begin inst_type = TYPE_ARITH; inst_opcode = ALU_SUB;  end
          {F7_BASE, 3'b010}: begin inst_type = TYPE_ARITH; inst_opcode = ALU_SLT;  end
          {F7_BASE, 3'b011}: begin inst_type = TYPE_ARITH; inst_opcode = ALU_SLTU; end
          {F7_BASE, 3'b111}: begin inst_type = TYPE_LOGIC; inst_opcode = ALU_AND;  end
          {F7_BASE, 3'b110}: begin inst_type = TYPE_LOGIC; inst_opcode = ALU_OR;   end
          {F7_BASE, 3'b100}: begin inst_type = TYPE_LOGIC; inst_opcode = ALU_XOR;  end
          {F7_BASE, 3'b001}: begin inst_type = TYPE_LOGIC; inst_opcode = ALU_SLL;  end
          {F7_BASE, 3'b101}: begin inst_type = TYPE_LOGIC; inst_opcode = ALU_SRL;  end
          {F7_ALT,  3'b101}: begin inst_type = TYPE_LOGIC; inst_opcode = ALU_SRA;  end
          default:           illegal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        inst_type   = TYPE_ARITH;
        inst_opcode = ALU_LUI;
        imm_fmt     = IMM_U;
        op1_sel     = OP1_ZERO;
      end
      OPC_AUIPC: begin
        inst_type   = TYPE_ARITH;
        inst_opcode = ALU_AUIPC;
        imm_fmt     = IMM_U;
        op1_sel     = OP1_PC;
      end
      OPC_JAL: begin
        inst_type   = TYPE_JUMP;
        inst_opcode = JMP_JAL;
        imm_fmt     = IMM_J;
        op1_sel     = OP1_PC;
        op2_sel     = OP2_FOUR;
      end
      OPC_JALR: begin
        inst_type   = TYPE_JUMP;
        inst_opcode = JMP_JALR;
        imm_fmt     = IMM_I;
        rs1_used    = 1'b1;
        op1_sel     = OP1_PC;
        op2_sel     = OP2_FOUR;
        illegal     = (funct3 != 3'b000);
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      inst_type   = '0;
      inst_opcode = '0;
      rs1_used    = 1'b0;
      rs2_used    = 1'b0;
    end
  end

  always_comb begin
    imm = '0;
    case (imm_fmt)
      IMM_I:     imm = DATA_WIDTH'($signed(inst[31:20]));
      IMM_SHAMT: imm = DATA_WIDTH'(inst[20 +: SHAMT_W]);
      IMM_U:     imm = DATA_WIDTH'($signed({inst[31:12], 12'b0}));
      IMM_J:     imm = DATA_WIDTH'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      default:   imm = '0;
    endcase
  end

  assign rd_w_ena  = !illegal && (rd != 5'd0);
  assign rd_w_addr = rd_w_ena ? rd : 5'd0;

endmodule

// File: rtl/id_stage_pipe.sv
// Registered decode stage: regfile read ports, operand muxing, valid/ready pipe register.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned PC_WIDTH   = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PC_WIDTH-1:0]   in_pc,
  input  logic [31:0]           in_inst,
  input  logic                  flush,
  output logic                  rs1_r_ena,
  output logic [4:0]            rs1_r_addr,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  output logic                  rs2_r_ena,
  output logic [4:0]            rs2_r_addr,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [4:0]            out_inst_type,
  output logic [7:0]            out_inst_opcode,
  output logic [DATA_WIDTH-1:0] out_op1,
  output logic [DATA_WIDTH-1:0] out_op2,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic                  out_rd_w_ena,
  output logic [4:0]            out_rd_w_addr,
  output logic                  out_illegal
);

  logic                  dec_illegal;
  logic [4:0]            dec_type;
  logic [7:0]            dec_opcode;
  logic [DATA_WIDTH-1:0] dec_imm;
  logic                  dec_rs1_used;
  logic                  dec_rs2_used;
  op1_sel_e              dec_op1_sel;
  op2_sel_e              dec_op2_sel;
  logic                  dec_rd_w_ena;
  logic [4:0]            dec_rd_w_addr;

  id_decode #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
    .inst        (in_inst),
    .illegal     (dec_illegal),
    .inst_type   (dec_type),
    .inst_opcode (dec_opcode),
    .imm         (dec_imm),
    .rs1_used    (dec_rs1_used),
    .rs2_used    (dec_rs2_used),
    .op1_sel     (dec_op1_sel),
    .op2_sel     (dec_op2_sel),
    .rd_w_ena    (dec_rd_w_ena),
    .rd_w_addr   (dec_rd_w_addr)
  );

  logic                  valid_q,     valid_d;
  logic [PC_WIDTH-1:0]   pc_q,        pc_d;
  logic [4:0]            type_q,      type_d;
  logic [7:0]            opcode_q,    opcode_d;
  logic [DATA_WIDTH-1:0] op1_q,       op1_d;
  logic [DATA_WIDTH-1:0] op2_q,       op2_d;
  logic [DATA_WIDTH-1:0] imm_q,       imm_d;
  logic                  rd_w_ena_q,  rd_w_ena_d;
  logic [4:0]            rd_w_addr_q, rd_w_addr_d;
  logic                  illegal_q,   illegal_d;

  logic                  accept;
  logic [DATA_WIDTH-1:0] op1_sel_val;
  logic [DATA_WIDTH-1:0] op2_sel_val;
  logic [DATA_WIDTH-1:0] imm_sel_val;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  assign rs1_r_ena  = in_valid && dec_rs1_used;
  assign rs1_r_addr = rs1_r_ena ? in_inst[19:15] : 5'd0;
  assign rs2_r_ena  = in_valid && dec_rs2_used;
  assign rs2_r_addr = rs2_r_ena ? in_inst[24:20] : 5'd0;

  always_comb begin
    op1_sel_val = '0;
    op2_sel_val = '0;
    case (dec_op1_sel)
      OP1_RS1: op1_sel_val = rs1_data;
      OP1_PC:  op1_sel_val = DATA_WIDTH'(in_pc);
      default: op1_sel_val = '0;
    endcase
    case (dec_op2_sel)
      OP2_RS2:  op2_sel_val = rs2_data;
      OP2_FOUR: op2_sel_val = DATA_WIDTH'(4);
      default:  op2_sel_val = dec_imm;
    endcase
    if (dec_illegal) begin
      op1_sel_val = '0;
      op2_sel_val = '0;
    end
    // Jumps carry the target offset in imm while op2 holds the link increment.
    imm_sel_val = (dec_type == TYPE_JUMP) ? dec_imm : op2_sel_val;
  end

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    type_d      = type_q;
    opcode_d    = opcode_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    imm_d       = imm_q;
    rd_w_ena_d  = rd_w_ena_q;
    rd_w_addr_d = rd_w_addr_q;
    illegal_d   = illegal_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d     = 1'b1;
      pc_d        = in_pc;
      type_d      = dec_type;
      opcode_d    = dec_opcode;
      op1_d       = op1_sel_val;
      op2_d       = op2_sel_val;
      imm_d       = imm_sel_val;
      rd_w_ena_d  = dec_rd_w_ena;
      rd_w_addr_d = dec_rd_w_addr;
      illegal_d   = dec_illegal;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      type_q      <= '0;
      opcode_q    <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      imm_q       <= '0;
      rd_w_ena_q  <= 1'b0;
      rd_w_addr_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      type_q      <= type_d;
      opcode_q    <= opcode_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      imm_q       <= imm_d;
      rd_w_ena_q  <= rd_w_ena_d;
      rd_w_addr_q <= rd_w_addr_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid       = valid_q;
  assign out_pc          = pc_q;
  assign out_inst_type   = type_q;
  assign out_inst_opcode = opcode_q;
  assign out_op1         = op1_q;
  assign out_op2         = op2_q;
  assign out_imm         = imm_q;
  assign out_rd_w_ena    = rd_w_ena_q;
  assign out_rd_w_addr   = rd_w_addr_q;
  assign out_illegal     = illegal_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Randomized bench for id_stage_pipe against a one-entry behavioural decode model.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_inst;
  logic        flush;
  logic        rs1_r_ena;
  logic [4:0]  rs1_r_addr;
  logic [63:0] rs1_data;
  logic        rs2_r_ena;
  logic [4:0]  rs2_r_addr;
  logic [63:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [4:0]  out_inst_type;
  logic [7:0]  out_inst_opcode;
  logic [63:0] out_op1;
  logic [63:0] out_op2;
  logic [63:0] out_imm;
  logic        out_rd_w_ena;
  logic [4:0]  out_rd_w_addr;
  logic        out_illegal;

  always #5 clk = ~clk;

  id_stage_pipe #(.DATA_WIDTH(64), .PC_WIDTH(64)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_pc           (in_pc),
    .in_inst         (in_inst),
    .flush           (flush),
    .rs1_r_ena       (rs1_r_ena),
    .rs1_r_addr      (rs1_r_addr),
    .rs1_data        (rs1_data),
    .rs2_r_ena       (rs2_r_ena),
    .rs2_r_addr      (rs2_r_addr),
    .rs2_data        (rs2_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst_type   (out_inst_type),
    .out_inst_opcode (out_inst_opcode),
    .out_op1         (out_op1),
    .out_op2         (out_op2),
    .out_imm         (out_imm),
    .out_rd_w_ena    (out_rd_w_ena),
    .out_rd_w_addr   (out_rd_w_addr),
    .out_illegal     (out_illegal)
  );

  typedef struct packed {
    bit        legal;
    bit [4:0]  typ;
    bit [7:0]  code;
    bit [63:0] op1;
    bit [63:0] op2;
    bit [63:0] imm;
    bit        rd_en;
    bit [4:0]  rd_addr;
    bit        rs1;
    bit        rs2;
  } exp_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  bit          m_valid;
  exp_t        m_e;
  bit [63:0]   m_pc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected decode straight from the instruction set rules.
  function automatic exp_t ref_dec(input bit [31:0] inst, input bit [63:0] pc,
                                   input bit [63:0] r1, input bit [63:0] r2);
    exp_t      e;
    bit [11:0] i12;
    bit [31:0] u32;
    bit [20:0] j21;
    longint    iimm, uimm, jimm;
    bit        jump;
    e     = '0;
    i12   = inst[31:20];
    u32   = {inst[31:12], 12'h000};
    j21   = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    iimm  = $signed(i12);
    uimm  = $signed(u32);
    jimm  = $signed(j21);
    jump  = 1'b0;
    e.legal = 1'b1;
    case (inst[6:0])
      7'h13: begin
        e.rs1 = 1'b1; e.op1 = r1; e.op2 = iimm;
        case (inst[14:12])
          3'd0: e.code = 8'h11;
          3'd2: e.code = 8'h13;
          3'd3: e.code = 8'h14;
          3'd4: e.code = 8'h23;
          3'd6: e.code = 8'h22;
          3'd7: e.code = 8'h21;
          3'd1: begin
            e.op2 = {58'b0, inst[25:20]};
            if (inst[31:26] == 6'h00) e.code = 8'h24; else e.legal = 1'b0;
          end
          default: begin
            e.op2 = {58'b0, inst[25:20]};
            if (inst[31:26] == 6'h00) e.code = 8'h25;
            else if (inst[31:26] == 6'h10) e.code = 8'h26;
            else e.legal = 1'b0;
          end
        endcase
      end
      7'h33: begin
        e.rs1 = 1'b1; e.rs2 = 1'b1; e.op1 = r1; e.op2 = r2;
        case ({inst[31:25], inst[14:12]})
          {7'h00, 3'd0}: e.code = 8'h11;
          {7'h20, 3'd0}: e.code = 8'h12;
          {7'h00, 3'd1}: e.code = 8'h24;
          {7'h00, 3'd2}: e.code = 8'h13;
          {7'h00, 3'd3}: e.code = 8'h14;
          {7'h00, 3'd4}: e.code = 8'h23;
          {7'h00, 3'd5}: e.code = 8'h25;
          {7'h20, 3'd5}: e.code = 8'h26;
          {7'h00, 3'd6}: e.code = 8'h22;
          {7'h00, 3'd7}: e.code = 8'h21;
          default:       e.legal = 1'b0;
        endcase
      end
      7'h37: begin e.op1 = 64'd0; e.op2 = uimm; e.code = 8'h15; end
      7'h17: begin e.op1 = pc;    e.op2 = uimm; e.code = 8'h16; end
      7'h6F: begin jump = 1'b1; e.op1 = pc; e.op2 = 64'd4; e.imm = jimm; e.code = 8'h41; end
      7'h67: begin
        jump = 1'b1; e.rs1 = 1'b1; e.op1 = pc; e.op2 = 64'd4; e.imm = iimm; e.code = 8'h42;
        if (inst[14:12] != 3'd0) e.legal = 1'b0;
      end
      default: e.legal = 1'b0;
    endcase
    if (!jump) e.imm = e.op2;
    case (e.code[7:4])
      4'h1:    e.typ = 5'b10000;
      4'h2:    e.typ = 5'b01000;
      4'h4:    e.typ = 5'b00010;
      default: e.typ = 5'b00000;
    endcase
    if (!e.legal) begin e.code = 8'h00; e.typ = 5'b00000; end
    e.rd_en   = e.legal && (inst[11:7] != 5'd0);
    e.rd_addr = e.rd_en ? inst[11:7] : 5'd0;
    return e;
  endfunction

  function automatic bit [31:0] rand_inst(input bit legal_only);
    bit [31:0] w;
    int        k;
    do begin
      w = $urandom;
      k = legal_only ? $urandom_range(0, 7) : $urandom_range(0, 9);
      case (k)
        0, 1: begin
          w[6:0] = 7'h13;
          if ((w[14:12] == 3'd1 || w[14:12] == 3'd5) && $urandom_range(0, 7) != 0)
            w[31:26] = (w[14:12] == 3'd5 && w[30]) ? 6'h10 : 6'h00;
        end
        2, 3: begin
          w[6:0] = 7'h33;
          case ($urandom_range(0, 5))
            0, 1, 2: w[31:25] = 7'h00;
            3, 4:    w[31:25] = 7'h20;
            default: ;
          endcase
        end
        4: w[6:0] = 7'h37;
        5: w[6:0] = 7'h17;
        6: w[6:0] = 7'h6F;
        7: begin
          w[6:0] = 7'h67;
          if ($urandom_range(0, 4) != 0) w[14:12] = 3'd0;
        end
        default: ;
      endcase
    end while (legal_only && !ref_dec(w, 64'd0, 64'd0, 64'd0).legal);
    return w;
  endfunction

  task automatic check_outputs();
    check_eq("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      check_eq("out_pc", out_pc, m_pc);
      check_eq("out_illegal", 64'(out_illegal), 64'(!m_e.legal));
      check_eq("out_inst_type", 64'(out_inst_type), 64'(m_e.typ));
      check_eq("out_inst_opcode", 64'(out_inst_opcode), 64'(m_e.code));
      check_eq("out_rd_w_ena", 64'(out_rd_w_ena), 64'(m_e.rd_en));
      if (m_e.legal) begin
        check_eq("out_rd_w_addr", 64'(out_rd_w_addr), 64'(m_e.rd_addr));
        check_eq("out_op1", out_op1, m_e.op1);
        check_eq("out_op2", out_op2, m_e.op2);
        check_eq("out_imm", out_imm, m_e.imm);
      end
    end
  endtask

  // One clock of stimulus: check handshake/read ports mid-cycle, then registered state after the edge.
  task automatic drive_cycle(input bit v, input bit [31:0] inst, input bit [63:0] pc,
                             input bit [63:0] r1, input bit [63:0] r2,
                             input bit ordy, input bit fl);
    exp_t cur;
    bit   acc;
    bit   e1, e2;
    in_valid = v; in_inst = inst; in_pc = pc;
    rs1_data = r1; rs2_data = r2; out_ready = ordy; flush = fl;
    #2;
    cur = ref_dec(inst, pc, r1, r2);
    check_eq("in_ready", 64'(in_ready), 64'(!m_valid || ordy));
    if (cur.legal) begin
      e1 = v && cur.rs1;
      e2 = v && cur.rs2;
      check_eq("rs1_r_ena", 64'(rs1_r_ena), 64'(e1));
      check_eq("rs1_r_addr", 64'(rs1_r_addr), e1 ? 64'(inst[19:15]) : 64'd0);
      check_eq("rs2_r_ena", 64'(rs2_r_ena), 64'(e2));
      check_eq("rs2_r_addr", 64'(rs2_r_addr), e2 ? 64'(inst[24:20]) : 64'd0);
    end
    acc = v && (!m_valid || ordy) && !fl;
    @(posedge clk);
    #1;
    if (fl) m_valid = 1'b0;
    else if (acc) begin m_valid = 1'b1; m_e = cur; m_pc = pc; end
    else if (ordy) m_valid = 1'b0;
    check_outputs();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_inst = 32'hFFD08293; in_pc = 64'd0;
    rs1_data = 64'd10; rs2_data = 64'd0; out_ready = 1'b0; flush = 1'b0;
    m_valid = 1'b0; m_e = '0; m_pc = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_pc", out_pc, 64'd0);
    check_eq("rst_out_type", 64'(out_inst_type), 64'd0);
    check_eq("rst_out_opcode", 64'(out_inst_opcode), 64'd0);
    check_eq("rst_out_op1", out_op1, 64'd0);
    check_eq("rst_out_op2", out_op2, 64'd0);
    check_eq("rst_out_imm", out_imm, 64'd0);
    check_eq("rst_rd_w_ena", 64'(out_rd_w_ena), 64'd0);
    check_eq("rst_rd_w_addr", 64'(out_rd_w_addr), 64'd0);
    check_eq("rst_illegal", 64'(out_illegal), 64'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);

    // addi x5,x1,-3
    drive_cycle(1'b1, 32'hFFD08293, 64'h0, 64'd10, 64'd0, 1'b1, 1'b0);
    check_eq("addi_valid", 64'(out_valid), 64'd1);
    check_eq("addi_type", 64'(out_inst_type), 64'h10);
    check_eq("addi_opcode", 64'(out_inst_opcode), 64'h11);
    check_eq("addi_op1", out_op1, 64'd10);
    check_eq("addi_op2", out_op2, 64'hFFFF_FFFF_FFFF_FFFD);
    check_eq("addi_rd_w_ena", 64'(out_rd_w_ena), 64'd1);
    check_eq("addi_rd_w_addr", 64'(out_rd_w_addr), 64'd5);

    // sub x3,x1,x2 then stall three cycles with lui waiting
    drive_cycle(1'b1, 32'h402081B3, 64'h4, 64'd100, 64'd30, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 32'h800003B7, 64'h8, 64'd7, 64'd9, 1'b0, 1'b0);
      check_eq("stall_opcode", 64'(out_inst_opcode), 64'h12);
      check_eq("stall_op1", out_op1, 64'd100);
      check_eq("stall_op2", out_op2, 64'd30);
      check_eq("stall_pc", out_pc, 64'h4);
    end
    drive_cycle(1'b1, 32'h800003B7, 64'h8, 64'd7, 64'd9, 1'b1, 1'b0);
    check_eq("lui_opcode", 64'(out_inst_opcode), 64'h15);
    check_eq("lui_op2", out_op2, 64'hFFFF_FFFF_8000_0000);

    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, rand_inst(1'b1), 64'h100 + 64'(4 * i),
                  {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
      check_eq("stream_valid", 64'(out_valid), 64'd1);
      check_eq("stream_pc", out_pc, 64'h100 + 64'(4 * i));
    end

    // jal x1,+8
    drive_cycle(1'b1, 32'h008000EF, 64'h1000, 64'h55, 64'h66, 1'b1, 1'b0);
    check_eq("jal_type", 64'(out_inst_type), 64'h02);
    check_eq("jal_opcode", 64'(out_inst_opcode), 64'h41);
    check_eq("jal_op1", out_op1, 64'h1000);
    check_eq("jal_op2", out_op2, 64'd4);
    check_eq("jal_imm", out_imm, 64'd8);

    drive_cycle(1'b1, 32'h0000007F, 64'h1004, 64'd1, 64'd2, 1'b1, 1'b0);
    check_eq("ill_valid", 64'(out_valid), 64'd1);
    check_eq("ill_flag", 64'(out_illegal), 64'd1);
    check_eq("ill_rd_w_ena", 64'(out_rd_w_ena), 64'd0);
    check_eq("ill_type", 64'(out_inst_type), 64'd0);

    // held entry plus incoming instruction, both discarded by flush
    drive_cycle(1'b1, 32'hFFD08293, 64'h2000, 64'd3, 64'd0, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'hFFD08293, 64'h2000, 64'd3, 64'd0, 1'b0, 1'b1);
    check_eq("flush_valid", 64'(out_valid), 64'd0);
    drive_cycle(1'b0, 32'hFFD08293, 64'h2004, 64'd3, 64'd0, 1'b1, 1'b0);
    check_eq("flush_no_accept", 64'(out_valid), 64'd0);

    for (int i = 0; i < 400; i++) begin
      drive_cycle($urandom_range(0, 9) < 8, rand_inst(1'b0), {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom},
                  $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Registered, handshaked successor to the single-instruction decode stage.
- Decodes RV64I integer ALU, LUI/AUIPC and JAL/JALR instructions.
- Drives register-file read ports combinationally and presents operands, immediate and control in a one-entry pipeline register towards EX.
- Sits between IF (valid/ready) and EX (valid/ready), with a flush input for redirects.

Parameters:
DATA_WIDTH, 64, operand/register width; shift-amount width is 6 when 64, 5 when 32
PC_WIDTH, 64, program counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  IF presents an instruction
in_ready  out  1  stage can accept
in_pc  in  PC_WIDTH  instruction address
in_inst  in  32  instruction word
flush  in  1  discard held and incoming instruction
rs1_r_ena  out  1  rs1 read enable
rs1_r_addr  out  5  rs1 index
rs1_data  in  DATA_WIDTH  rs1 value (async regfile read)
rs2_r_ena  out  1  rs2 read enable
rs2_r_addr  out  5  rs2 index
rs2_data  in  DATA_WIDTH  rs2 value
out_valid  out  1  decoded instruction held
out_ready  in  1  EX accepts
out_pc  out  PC_WIDTH  instruction address
out_inst_type  out  5  one-hot class: arith 10000, logic 01000, ld/st 00100, jump 00010, sys 00001
out_inst_opcode  out  8  operation code (package constants)
out_op1  out  DATA_WIDTH  first operand
out_op2  out  DATA_WIDTH  second operand
out_imm  out  DATA_WIDTH  sign-extended immediate (jump offset for JAL/JALR)
out_rd_w_ena  out  1  writeback enable
out_rd_w_addr  out  5  destination index
out_illegal  out  1  unsupported/malformed encoding

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset: every registered output is 0; in_ready = 1 after reset.
- in_ready = !out_valid || out_ready. Accept = in_valid && in_ready && !flush.
- Latency: one cycle. Accepted instruction appears in the output register on the next edge.
- Output register is loaded only on accept. If out_ready is asserted with no accept, out_valid clears. Otherwise the register holds all fields stable while out_valid && !out_ready.
- flush: out_valid clears next edge and no accept occurs that cycle. Flush takes priority over a simultaneous accept or hold.
- Read ports are combinational from in_inst and gated by in_valid. rsN_r_ena = 1 only when the class reads rsN; address is 0 otherwise. rsN_data is sampled at the accept edge.
- Operation codes:
  - arith: ADD 11h, SUB 12h, SLT 13h, SLTU 14h, LUI 15h, AUIPC 16h
  - logic: AND 21h, OR 22h, XOR 23h, SLL 24h, SRL 25h, SRA 26h
  - jump: JAL 41h, JALR 42h
- Operand selection:
  - OP-IMM: op1 = rs1_data, op2 = sext(I-imm). Shifts use op2 = zero-extended shamt.
  - OP: op1 = rs1_data, op2 = rs2_data.
  - LUI: op1 = 0, op2 = sext({inst[31:12], 12'b0}).
  - AUIPC: op1 = pc (zero-extended to DATA_WIDTH), op2 = U-imm.
  - JAL/JALR: op1 = pc, op2 = 4. imm = sext(J-imm) for JAL; imm = sext(I-imm) for JALR, whose rs1_data lands in op1 only via EX forwarding and so is not placed in op1.
  - imm equals op2 for non-jump classes.
- Illegal: any other major opcode, bad funct7, funct3 != 0 on JALR, or shamt high bits set beyond width. Response:
  - out_illegal = 1, inst_type = 0, inst_opcode = 0, rd_w_ena = 0.
  - out_valid still asserts, so EX can trap.
- rd_w_ena = 1 for legal instructions with rd != 0; rd == x0 gives rd_w_ena = 0 and rd_w_addr = 0.

Decomposition:
- Package id_pkg holds:
  - RISC-V major opcode constants (OP_IMM 0010011, OP 0110011, LUI, AUIPC, JAL, JALR)
  - inst_type one-hot constants and inst_opcode constants
  - immediate-format enum
- Sub-module id_decode: purely combinational inst → type/opcode/imm/enables/illegal.
- id_stage_pipe owns the read ports, operand muxing, handshake and output register.

Test Plan:
- Reset with rst_n = 0 for 2 cycles while in_valid = 1 → all outputs 0, out_valid = 0. First cycle with rst_n = 1 gives in_ready = 1.
- addi x5,x1,-3 (FFD08293h), rs1_data = 10, out_ready = 1 → next cycle:
  - out_valid = 1, type 10000, opcode 11h
  - op1 = 10, op2 = FFFF_FFFF_FFFF_FFFDh
  - rd_w_ena = 1, rd_w_addr = 5
- sub x3,x1,x2 (402081B3h) with out_ready = 0 for 3 cycles → fields held constant, in_ready = 0, no new accept. Release out_ready → next queued lui x7,0x80000 (800003B7h) gives op2 = FFFF_FFFF_8000_0000h.
- Back-to-back stream of 8 instructions, out_ready = 1 always → one output per cycle, in order, no bubbles.
- jal x1,+8 at pc = 1000h → type 00010, opcode 41h, op1 = 1000h, op2 = 4, imm = 8, rs1_r_ena = 0.
- Encoding 0000007Fh → out_illegal = 1, rd_w_ena = 0. flush asserted together with in_valid and a held instruction → out_valid = 0 next cycle, nothing accepted.
